// File: rtl/bl_wl_config_driver.sv
// rtl/bl_wl_config_driver.sv - BL/WL configuration writer for a tile column (optional CFG_PARITY_EN)
module bl_wl_config_driver #(
    parameter int BL_WIDTH  = 315,
    parameter int WL_WIDTH  = 4,
    parameter int DIN_W     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [DIN_W-1:0]    din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [BL_WIDTH-1:0] bl_out,
    output logic [WL_WIDTH-1:0] wl_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int NW      = (BL_WIDTH + DIN_W - 1) / DIN_W;
`ifdef CFG_PARITY_EN
    localparam int NWORDS  = NW + 1;
`else
    localparam int NWORDS  = NW;
`endif
    localparam int FRAME_W = NW * DIN_W;
    localparam int K_W     = $clog2(NWORDS + 1);
    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_PH  = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int PH_W    = $clog2(MAX_PH + 1);
    localparam int ROW_W   = $clog2(WL_WIDTH) + 1;

    localparam logic [K_W-1:0]   K_LAST     = K_W'(NW - 1);
`ifdef CFG_PARITY_EN
    localparam logic [K_W-1:0]   K_PAR      = K_W'(NW);
`endif
    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0]  PULSE_LAST = PH_W'(PULSE_CYC - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(HOLD_CYC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(WL_WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]          r_state;
    logic [K_W-1:0]      r_k;
    logic [ROW_W-1:0]    r_row;
    logic [PH_W-1:0]     r_ph;
    logic [FRAME_W-1:0]  r_frame;
    logic                r_err;
    logic [BL_WIDTH-1:0] r_bl_out;
    logic [WL_WIDTH-1:0] r_wl_out;
    logic                r_busy;
    logic                r_done;
    logic                r_din_ready;

    logic [2:0]          w_state_nxt;
    logic [K_W-1:0]      w_k_nxt;
    logic [ROW_W-1:0]    w_row_nxt;
    logic [PH_W-1:0]     w_ph_nxt;
    logic [FRAME_W-1:0]  w_frame_nxt;
    logic                w_err_nxt;
    logic                w_accept;
    logic                w_drive;

    // din_ready mirrors the LOAD state, so it is the handshake qualifier
    assign w_accept = r_din_ready & din_valid;

    // Next-state logic: frame assembly, phase timing, row sequencing, abort
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_row_nxt   = r_row;
        w_ph_nxt    = r_ph;
        w_frame_nxt = r_frame;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_k_nxt     = '0;
                    w_row_nxt   = '0;
                    w_frame_nxt = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    // Word k lands at bits k*DIN_W upward; bits past BL_WIDTH are never driven out
                    for (int w = 0; w < NW; w++) begin
                        if (r_k == K_W'(w)) begin
                            w_frame_nxt[w*DIN_W +: DIN_W] = din;
                        end
                    end
                    w_k_nxt = r_k + 1'b1;
`ifdef CFG_PARITY_EN
                    if (r_k == K_PAR) begin
                        w_ph_nxt = '0;
                        if (din[0] == ^r_frame[BL_WIDTH-1:0]) begin
                            w_state_nxt = S_SETUP;
                        end else begin
                            // Corrupt frame: skip the WL pulse and finish the configuration
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_DONE;
                        end
                    end
`else
                    if (r_k == K_LAST) begin
                        w_ph_nxt    = '0;
                        w_state_nxt = S_SETUP;
                    end
`endif
                end
            end
            S_SETUP: begin
                if (r_ph == SETUP_LAST) begin
                    w_ph_nxt    = '0;
                    w_state_nxt = S_PULSE;
                end else begin
                    w_ph_nxt = r_ph + 1'b1;
                end
            end
            S_PULSE: begin
                if (r_ph == PULSE_LAST) begin
                    w_ph_nxt    = '0;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_ph_nxt = r_ph + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_ph == HOLD_LAST) begin
                    w_ph_nxt = '0;
                    if (r_row == ROW_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_row_nxt   = r_row + 1'b1;
                        w_k_nxt     = '0;
                        w_frame_nxt = '0;
                        w_state_nxt = S_LOAD;
                    end
                end else begin
                    w_ph_nxt = r_ph + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort wins over every transition but leaves the error flag alone
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_k_nxt     = '0;
            w_row_nxt   = '0;
            w_ph_nxt    = '0;
            w_err_nxt   = r_err;
        end
    end

    assign w_drive = (w_state_nxt == S_SETUP) || (w_state_nxt == S_PULSE) || (w_state_nxt == S_HOLD);

    // State and registered outputs, decoded from the next state so outputs align with the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_row       <= '0;
            r_ph        <= '0;
            r_frame     <= '0;
            r_err       <= 1'b0;
            r_bl_out    <= '0;
            r_wl_out    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_din_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_row       <= w_row_nxt;
            r_ph        <= w_ph_nxt;
            r_frame     <= w_frame_nxt;
            r_err       <= w_err_nxt;
            r_bl_out    <= w_drive ? w_frame_nxt[BL_WIDTH-1:0] : '0;
            r_wl_out    <= (w_state_nxt == S_PULSE) ? (WL_WIDTH'(1) << w_row_nxt) : '0;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            r_din_ready <= (w_state_nxt == S_LOAD);
        end
    end

    assign din_ready = r_din_ready;
    assign bl_out    = r_bl_out;
    assign wl_out    = r_wl_out;
    assign busy      = r_busy;
    assign done      = r_done;
`ifdef CFG_PARITY_EN
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_bl_wl_config_driver.sv
// tb/tb_bl_wl_config_driver.sv - self-checking bench for bl_wl_config_driver
module tb_bl_wl_config_driver;

    localparam int BLW = 10;
    localparam int WLW = 2;
    localparam int DW  = 4;
    localparam int SC  = 1;
    localparam int PC  = 2;
    localparam int HC  = 1;
    localparam int NW  = (BLW + DW - 1) / DW;
`ifdef CFG_PARITY_EN
    localparam int NWORDS = NW + 1;
`else
    localparam int NWORDS = NW;
`endif

    logic           clk;
    logic           reset;
    logic           start;
    logic           abort;
    logic [DW-1:0]  din;
    logic           din_valid;
    logic           din_ready;
    logic [BLW-1:0] bl_out;
    logic [WLW-1:0] wl_out;
    logic           busy;
    logic           done;
    logic           err;

    bl_wl_config_driver #(
        .BL_WIDTH(BLW), .WL_WIDTH(WLW), .DIN_W(DW),
        .SETUP_CYC(SC), .PULSE_CYC(PC), .HOLD_CYC(HC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .bl_out(bl_out), .wl_out(wl_out), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model: schedule of output cycles ----------------
    typedef struct {
        logic [BLW-1:0] bl;
        logic [WLW-1:0] wl;
        bit             dn;
    } item_t;

    item_t         sched[$];
    logic [DW-1:0] mwords[$];
    bit            m_active  = 0;
    bit            m_loading = 0;
    bit            m_err     = 0;
    int            m_row     = 0;

    task automatic model_frame_complete();
        logic [BLW-1:0] f;
        logic [WLW-1:0] one;
        bit             ok;
        f = '0;
        for (int i = 0; i < BLW; i++) f[i] = mwords[i / DW][i % DW];
`ifdef CFG_PARITY_EN
        ok = (mwords[NW][0] == ^f);
`else
        ok = 1;
`endif
        m_loading = 0;
        one = '0;
        one[m_row] = 1'b1;
        if (!ok) begin
            m_err = 1;
            sched.push_back('{bl: '0, wl: '0, dn: 1});
        end else begin
            for (int i = 0; i < SC; i++) sched.push_back('{bl: f, wl: '0, dn: 0});
            for (int i = 0; i < PC; i++) sched.push_back('{bl: f, wl: one, dn: 0});
            for (int i = 0; i < HC; i++) sched.push_back('{bl: f, wl: '0, dn: 0});
            if (m_row == WLW - 1) sched.push_back('{bl: '0, wl: '0, dn: 1});
        end
    endtask

    task automatic model_step();
        item_t it;
        if (!reset) begin
            m_active = 0; m_loading = 0; m_err = 0; m_row = 0;
            sched.delete(); mwords.delete();
        end else if (abort) begin
            m_active = 0; m_loading = 0; m_row = 0;
            sched.delete(); mwords.delete();
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_loading = 1; m_err = 0; m_row = 0;
                mwords.delete();
            end
        end else if (m_loading) begin
            if (din_valid) begin
                mwords.push_back(din);
                if (mwords.size() == NWORDS) model_frame_complete();
            end
        end else if (sched.size() > 0) begin
            it = sched.pop_front();
            if (sched.size() == 0) begin
                if (it.dn) m_active = 0;
                else begin
                    m_row++;
                    m_loading = 1;
                    mwords.delete();
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    // ---------------- per-cycle compare against the model ----------------
    initial forever begin
        logic [BLW+WLW+3:0] got, exp;
        logic [BLW-1:0] e_bl;
        logic [WLW-1:0] e_wl;
        bit e_dn;
        @(negedge clk);
        e_bl = '0; e_wl = '0; e_dn = 0;
        if (m_active && !m_loading && sched.size() > 0) begin
            e_bl = sched[0].bl; e_wl = sched[0].wl; e_dn = sched[0].dn;
        end
        exp = {m_active, e_dn, m_err, (m_active && m_loading), e_wl, e_bl};
        got = {busy, done, err, din_ready, wl_out, bl_out};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cycle t=%0t busy/done/err/rdy/wl/bl got=%h exp=%h", $time, got, exp);
        end
    end

    // ---------------- observation counters for literal expectations ----------------
    int c_a, c_a_wl, c_b, c_b_wl, c_done, c_wl_any;
    initial forever begin
        @(negedge clk);
        if (bl_out == 10'h3A5) c_a++;
        if (bl_out == 10'h3A5 && wl_out == 2'b01) c_a_wl++;
        if (bl_out == 10'h201) c_b++;
        if (bl_out == 10'h201 && wl_out == 2'b10) c_b_wl++;
        if (done) c_done++;
        if (wl_out != '0) c_wl_any++;
    end

    task automatic clr();
        @(posedge clk);
        c_a = 0; c_a_wl = 0; c_b = 0; c_b_wl = 0; c_done = 0; c_wl_any = 0;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    logic [DW-1:0] wq[$];

    task automatic full_words();
        wq = {4'h5, 4'hA, 4'hF};
`ifdef CFG_PARITY_EN
        wq.push_back(4'h0);
`endif
        wq.push_back(4'h1); wq.push_back(4'h0); wq.push_back(4'h2);
`ifdef CFG_PARITY_EN
        wq.push_back(4'h0);
`endif
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_words(input bit gaps);
        int idx = 0;
        int guard = 0;
        while (idx < wq.size() && guard < 400) begin
            @(negedge clk);
            din       = wq[idx];
            din_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (din_valid && din_ready) idx++;
            guard++;
        end
        @(negedge clk);
        din_valid = 1'b0; start = 1'b0;
        check("send_words_complete", idx, wq.size());
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_wl(input logic [WLW-1:0] v);
        int n = 0;
        while (wl_out != v && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wait_wl_timeout", int'(wl_out), int'(v));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; din = '0; din_valid = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bl", int'(bl_out), 0);
        check("rst_wl", int'(wl_out), 0);
        check("rst_busy_done_rdy_err", int'({busy, done, din_ready, err}), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Two full frames, no stalls
        clr(); full_words(); do_start(); send_words(0); wait_idle();
        check("f0_bl_cycles", c_a, 4);
        check("f0_wl_cycles", c_a_wl, 2);
        check("f1_bl_cycles", c_b, 4);
        check("f1_wl_cycles", c_b_wl, 2);
        check("done_pulses", c_done, 1);

        // Same configuration with random valid gaps and stray start pulses
        clr(); full_words(); do_start(); send_words(1); wait_idle();
        check("gap_f0_bl_cycles", c_a, 4);
        check("gap_f0_wl_cycles", c_a_wl, 2);
        check("gap_f1_bl_cycles", c_b, 4);
        check("gap_f1_wl_cycles", c_b_wl, 2);
        check("gap_done_pulses", c_done, 1);

        // Abort during second frame's pulse
        clr(); full_words(); do_start(); send_words(0); wait_wl(2'b10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_bl", int'(bl_out), 0);
        check("abort_wl", int'(wl_out), 0);
        check("abort_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        check("abort_no_done", c_done, 0);
        clr(); full_words(); do_start(); send_words(0); wait_idle();
        check("reconf_f0_wl", c_a_wl, 2);
        check("reconf_f1_wl", c_b_wl, 2);
        check("reconf_done", c_done, 1);

        // Reset asserted in the middle of a pulse
        clr();
        wq = {4'h5, 4'hA, 4'hF};
`ifdef CFG_PARITY_EN
        wq.push_back(4'h0);
`endif
        do_start(); send_words(0); wait_wl(2'b01);
        #2 reset = 1'b0;
        #1;
        check("midrst_wl", int'(wl_out), 0);
        check("midrst_bl", int'(bl_out), 0);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_ready", int'(din_ready), 0);
        end

`ifdef CFG_PARITY_EN
        // Bad parity word: error, no pulse, done still pulses
        clr();
        wq = {4'h5, 4'hA, 4'hF, 4'h1};
        do_start(); send_words(0); wait_idle();
        check("par_bad_no_wl", c_wl_any, 0);
        check("par_bad_done", c_done, 1);
        check("par_bad_err", int'(err), 1);
        // Good parity: normal configuration, error cleared by start
        clr(); full_words(); do_start(); send_words(0); wait_idle();
        check("par_ok_wl", c_a_wl, 2);
        check("par_ok_err", int'(err), 0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
